// File: rtl/dmem_arbiter.sv
// Data-memory port arbiter: round-robin CPU/DMA single beats plus locked DMA bursts capped at MAX_BURST.
// Define DMEM_ARB_PERF_EN to build the saturating CPU stall-cycle counter on perf_stall_cnt.
module dmem_arbiter #(
  parameter int AW        = 32,
  parameter int DW        = 32,
  parameter int MAX_BURST = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cpu_req,
  input  logic          cpu_wen,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  input  logic [3:0]    cpu_byte_en,
  output logic          cpu_gnt,
  output logic          cpu_stall,
  output logic          cpu_rvalid,
  output logic [DW-1:0] cpu_rdata,
  input  logic          dma_req,
  input  logic          dma_wen,
  input  logic [AW-1:0] dma_addr,
  input  logic [DW-1:0] dma_wdata,
  input  logic [3:0]    dma_byte_en,
  input  logic          dma_lock,
  output logic          dma_gnt,
  output logic          dma_rvalid,
  output logic [DW-1:0] dma_rdata,
  output logic          mem_en,
  output logic          mem_wen,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic [3:0]    mem_byte_en,
  input  logic [DW-1:0] mem_rdata,
  output logic [31:0]   perf_stall_cnt
);

  localparam int CW = $clog2(MAX_BURST + 1);

  typedef enum logic {ARB, BURST} state_t;

  state_t        fsm;
  logic          last_owner;
  logic [CW-1:0] burst_cnt;
  logic          rd_owner;
  logic          rd_pending;
  logic          lock_block;

  logic          eff_lock;
  logic          arb_cycle;
  logic          cpu_win;
  logic          dma_win;
  logic [CW-1:0] cnt_next;

  // Grant decision: combinational, forced low while reset is asserted
  always_comb begin
    eff_lock  = dma_lock & ~lock_block;
    arb_cycle = (fsm == ARB) | ~eff_lock;
    cnt_next  = burst_cnt + CW'(1);
    cpu_win   = 1'b0;
    dma_win   = 1'b0;
    if (!rst) begin
      if (arb_cycle) begin
        if (cpu_req && dma_req) begin
          cpu_win = last_owner;
          dma_win = ~last_owner;
        end else begin
          cpu_win = cpu_req;
          dma_win = dma_req;
        end
      end else begin
        dma_win = dma_req;
      end
    end
  end

  assign cpu_gnt   = cpu_win;
  assign dma_gnt   = dma_win;
  assign cpu_stall = cpu_req & ~cpu_win & ~rst;

  assign mem_en      = cpu_win | dma_win;
  assign mem_wen     = cpu_win ? cpu_wen     : (dma_win ? dma_wen     : 1'b0);
  assign mem_addr    = cpu_win ? cpu_addr    : (dma_win ? dma_addr    : '0);
  assign mem_wdata   = cpu_win ? cpu_wdata   : (dma_win ? dma_wdata   : '0);
  assign mem_byte_en = cpu_win ? cpu_byte_en : (dma_win ? dma_byte_en : 4'b0000);

  assign cpu_rvalid = rd_pending & ~rd_owner;
  assign dma_rvalid = rd_pending & rd_owner;
  assign cpu_rdata  = cpu_rvalid ? mem_rdata : '0;
  assign dma_rdata  = dma_rvalid ? mem_rdata : '0;

  // Arbitration state, burst tracking and read-return bookkeeping
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm        <= ARB;
      last_owner <= 1'b1;
      burst_cnt  <= '0;
      rd_owner   <= 1'b0;
      rd_pending <= 1'b0;
      lock_block <= 1'b0;
    end else begin
      if (cpu_win || dma_win) begin
        last_owner <= dma_win;
        rd_owner   <= dma_win;
      end
      rd_pending <= (cpu_win & ~cpu_wen) | (dma_win & ~dma_wen);
      if (!dma_lock) lock_block <= 1'b0;
      case (fsm)
        ARB: begin
          if (dma_win && eff_lock) begin
            if (MAX_BURST == 1) begin
              lock_block <= 1'b1;
            end else begin
              fsm       <= BURST;
              burst_cnt <= CW'(1);
            end
          end
        end
        BURST: begin
          if (!dma_lock) begin
            fsm       <= ARB;
            burst_cnt <= '0;
          end else if (dma_win) begin
            // Beat that reaches the cap releases the port; lock must drop before it is honoured again
            if (cnt_next == CW'(MAX_BURST)) begin
              fsm        <= ARB;
              burst_cnt  <= '0;
              lock_block <= 1'b1;
            end else begin
              burst_cnt <= cnt_next;
            end
          end
        end
        default: fsm <= ARB;
      endcase
    end
  end

`ifdef DMEM_ARB_PERF_EN
  logic [31:0] stall_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (cpu_stall && (stall_cnt != 32'hFFFF_FFFF)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end

  assign perf_stall_cnt = stall_cnt;
`else
  assign perf_stall_cnt = 32'd0;
`endif

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Arbitrates the single data-memory port between the CPU memory stage and a second master (program loader / DMA engine). Fair round-robin grant for single beats, plus a locked-burst mode for the second master with a hard beat limit. Asserts a stall to the pipeline whenever the CPU requests and is not granted. Sits between the CPU memory-stage register and the data memory.

## Interface
- AW, 32, address width
- DW, 32, data width
- MAX_BURST, 8, maximum consecutive locked DMA beats before forced release (≥1)

- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- cpu_req  in  1  CPU requests an access this cycle
- cpu_wen  in  1  1 = store, 0 = load
- cpu_addr  in  AW  CPU byte address
- cpu_wdata  in  DW  CPU store data
- cpu_byte_en  in  4  CPU byte lanes
- cpu_gnt  out  1  CPU access issued to memory this cycle
- cpu_stall  out  1  cpu_req & ~cpu_gnt
- cpu_rvalid  out  1  CPU load data valid on cpu_rdata
- cpu_rdata  out  DW  CPU load data
- dma_req, dma_wen, dma_addr, dma_wdata, dma_byte_en  in  1/1/AW/DW/4  same meaning for DMA
- dma_lock  in  1  DMA requests burst ownership
- dma_gnt  out  1  DMA access issued this cycle
- dma_rvalid, dma_rdata  out  1/DW  DMA load return
- mem_en, mem_wen  out  1/1  memory command strobe / write
- mem_addr, mem_wdata, mem_byte_en  out  AW/DW/4  memory command fields
- mem_rdata  in  DW  read data, valid one cycle after mem_en & ~mem_wen
- perf_stall_cnt  out  32  CPU stall-cycle count (see Configuration)

## Operation
- State: fsm ∈ {ARB, BURST}; last_owner (0 = CPU, 1 = DMA); burst_cnt [$clog2(MAX_BURST+1)]; rd_owner, rd_pending.
- Grant is combinational from requests and registered state; at most one of cpu_gnt/dma_gnt high.
- ARB: single requester wins. Both request → the one ≠ last_owner wins. On any grant, last_owner ← winner.
- ARB → BURST: dma_gnt & dma_lock; burst_cnt ← 1.
- BURST: dma_gnt = dma_req; cpu_gnt = 0. Each DMA beat increments burst_cnt. Cycles with dma_req = 0 hold ownership without counting.
- BURST → ARB: dma_lock = 0 (that cycle is arbitrated as ARB), or beat with burst_cnt = MAX_BURST (forced release; last_owner ← DMA so CPU wins the next tie). After forced release, dma_lock is ignored until dma_lock has been low for ≥1 cycle.
- Memory mux: mem_* driven from granted requester; all mem_* = 0 when no grant.
- Read return: on granted load, rd_pending ← 1, rd_owner ← winner; next cycle rvalid of rd_owner = 1, its rdata = mem_rdata; other rdata = 0. Stores produce no rvalid.
- Address/data are passed through unmodified; alignment is the requester's responsibility.

## Timing
- Reset (async assert, sync release): fsm = ARB, last_owner = DMA, burst_cnt = 0, rd_pending = 0, perf_stall_cnt = 0; all outputs 0.
- Grant to mem command: 0 cycles. Load latency request → rvalid: 1 cycle. Back-to-back single-cycle accesses sustained at 1 per cycle.
- cpu_stall is combinational; pipeline must hold MEM-stage inputs stable while high.
- Reset during BURST or with a read pending: pending rvalid is dropped, no return delivered.
- Simultaneous dma_lock deassert and burst_cnt = MAX_BURST: single release, last_owner = DMA.

## Configuration
- DMEM_ARB_PERF_EN defined: perf_stall_cnt increments each cycle cpu_stall = 1, saturating at 32'hFFFF_FFFF, cleared only by rst.
- Not defined: counter logic omitted, perf_stall_cnt tied to 0.

## Test plan
- CPU-only load addr 0x0000_0100, mem_rdata = 0xDEAD_BEEF next cycle → cpu_gnt same cycle, mem_en = 1, mem_wen = 0; next cycle cpu_rvalid = 1, cpu_rdata = 0xDEAD_BEEF, dma_rvalid = 0.
- CPU store byte_en 4'b0011, data 0x1234_5678 → mem_wen = 1, mem_byte_en = 4'b0011, mem_wdata = 0x1234_5678, no rvalid next cycle.
- Both masters request continuously from reset, no lock → grants CPU, DMA, CPU, DMA…; cpu_stall high on DMA cycles only.
- MAX_BURST = 8, DMA lock + req for 12 cycles, CPU req throughout → dma_gnt 8 cycles, cpu_stall 8 cycles, cycle 9 cpu_gnt = 1, then alternation resumes.
- Assert rst mid-burst with a load pending → all outputs 0 immediately, no rvalid after release; first tie goes to CPU.
- With DMEM_ARB_PERF_EN, rerun burst scenario → perf_stall_cnt = 8; without macro → 0.
